// File: rtl/alu_pkg.sv
// Shared ALU types: op encoding, serial FSM states, default width.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_AND = 2'b00,
    ALU_OR  = 2'b01,
    ALU_ADD = 2'b10,
    ALU_SUB = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int ALU_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/alu_1bit.sv
// One-bit ALU slice; SUB inverts b so the caller supplies carry-in 1.
module alu_1bit
  import alu_pkg::*;
(
  input  logic    a,
  input  logic    b,
  input  logic    cin,
  input  alu_op_t op,
  output logic    res,
  output logic    cout
);

  logic bx;

  always_comb begin
    bx   = b ^ (op == ALU_SUB);
    res  = 1'b0;
    cout = 1'b0;
    unique case (op)
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_ADD,
      ALU_SUB: begin
        res  = a ^ bx ^ cin;
        cout = (a & bx) | (cin & (a ^ bx));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU: drives one alu_1bit slice LSB first for WIDTH cycles.
// zero/ovf flags exist only when ALU_SERIAL_FLAGS_EN is defined.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  alu_op_t          op_q;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             s_res;
  logic             s_cout;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] next_res;

  alu_1bit u_slice (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .op   (op_q),
    .res  (s_res),
    .cout (s_cout)
  );

  assign in_ready = !reset &&
    ((state == IDLE) || (state == DONE && out_ready));
  assign accept   = in_valid && in_ready;
  assign last     = (cnt == CW'(WIDTH - 1));
  assign next_res = {s_res, result[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= ALU_AND;
      a_sr      <= '0;
      b_sr      <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
      zero      <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else if (accept) begin
      // Acceptance from DONE consumes the old result on this same edge.
      state     <= RUN;
      op_q      <= alu_op_t'(op);
      a_sr      <= a;
      b_sr      <= b;
      cnt       <= '0;
      carry     <= (alu_op_t'(op) == ALU_SUB);
      out_valid <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          result <= next_res;
          carry  <= s_cout;
          cnt    <= cnt + 1'b1;
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            cout      <= s_cout;
`ifdef ALU_SERIAL_FLAGS_EN
            zero      <= (next_res == '0);
            // carry still holds the carry into the MSB here
            ovf       <= op_q[1] & (carry ^ s_cout);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifndef ALU_SERIAL_FLAGS_EN
  assign zero = 1'b0;
  assign ovf  = 1'b0;
`endif

endmodule
